// File: rtl/dsp_dot_sequencer_pkg.sv
// Shared types and widths for the dot-product sequencer and its DSP slice partner.
package dsp_dot_sequencer_pkg;

  localparam int unsigned ACC_W = 64;
  localparam int unsigned OP_W  = 27;
  localparam int unsigned PROD_W = 2 * OP_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } seq_state_e;

  // Signed 27x27 product, sign-extended to the accumulator width.
  function automatic logic [ACC_W-1:0] signed_product(input logic [OP_W-1:0] a,
                                                     input logic [OP_W-1:0] b);
    logic signed [PROD_W-1:0] p;
    p = $signed(a) * $signed(b);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/dsp_slice.sv
// Pipelined multiply-accumulate slice: a beat on the inputs reaches resulta LAT cycles later.
module dsp_slice
  import dsp_dot_sequencer_pkg::*;
#(
  parameter int unsigned LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  ay,
  input  logic [OP_W-1:0]  ax,
  input  logic             loadconst,
  input  logic             accumulate,
  input  logic             negate,
  input  logic [ACC_W-1:0] constant,
  output logic [ACC_W-1:0] resulta
);

  typedef struct packed {
    logic             ld;
    logic             acc;
    logic             neg;
    logic [ACC_W-1:0] cst;
    logic [ACC_W-1:0] prod;
  } beat_t;

  beat_t in_beat;
  beat_t head;
  logic [ACC_W-1:0] acc_q;

  always_comb begin
    in_beat      = '0;
    in_beat.ld   = loadconst;
    in_beat.acc  = accumulate;
    in_beat.neg  = negate;
    in_beat.cst  = constant;
    in_beat.prod = signed_product(ay, ax);
  end

  // LAT-1 delay stages ahead of the accumulator register.
  if (LAT > 1) begin : g_pipe
    beat_t pipe_q [LAT-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned i = 0; i < LAT - 1; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= in_beat;
        for (int unsigned i = 1; i < LAT - 1; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign head = pipe_q[LAT-2];
  end else begin : g_nopipe
    assign head = in_beat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (head.ld) begin
      acc_q <= head.cst;
    end else if (head.acc) begin
      acc_q <= head.neg ? (acc_q - head.prod) : (acc_q + head.prod);
    end
  end

  assign resulta = acc_q;

endmodule

// File: rtl/dsp_dot_sequencer.sv
// Sequences one dot-product job through an external DSP slice: load constant, stream pairs, drain, present result.
module dsp_dot_sequencer
  import dsp_dot_sequencer_pkg::*;
#(
  parameter int unsigned SLICE_LAT = 4,
  parameter int unsigned LEN_W     = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [LEN_W-1:0] job_len,
  input  logic [ACC_W-1:0] job_const,
  input  logic             job_neg,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [OP_W-1:0]  op_a,
  input  logic [OP_W-1:0]  op_b,
  output logic [OP_W-1:0]  ay,
  output logic [OP_W-1:0]  ax,
  output logic             loadconst,
  output logic             accumulate,
  output logic             negate,
  output logic [ACC_W-1:0] constant,
  input  logic [ACC_W-1:0] resulta,
  output logic             res_valid,
  output logic [ACC_W-1:0] res_data,
  input  logic             res_ready,
  output logic             busy
);

  localparam int unsigned DW = (SLICE_LAT > 1) ? $clog2(SLICE_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(SLICE_LAT - 1);

  seq_state_e       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] const_q, const_d;
  logic             neg_q, neg_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [ACC_W-1:0] res_q, res_d;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      const_q <= '0;
      neg_q   <= 1'b0;
      dcnt_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      const_q <= const_d;
      neg_q   <= neg_d;
      dcnt_q  <= dcnt_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    const_d    = const_q;
    neg_d      = neg_q;
    dcnt_d     = dcnt_q;
    res_d      = res_q;
    job_ready  = 1'b0;
    op_ready   = 1'b0;
    ay         = '0;
    ax         = '0;
    loadconst  = 1'b0;
    accumulate = 1'b0;
    negate     = 1'b0;
    constant   = '0;
    res_valid  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          len_d   = job_len;
          const_d = job_const;
          neg_d   = job_neg;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        loadconst = 1'b1;
        constant  = const_q;
        dcnt_d    = '0;
        state_d   = (len_q != '0) ? ST_STREAM : ST_DRAIN;
      end
      ST_STREAM: begin
        op_ready   = 1'b1;
        accumulate = 1'b1;
        negate     = neg_q;
        if (op_valid) begin
          ay    = op_a;
          ax    = op_b;
          cnt_d = cnt_q + 1'b1;
          // Compare against len-1 so a full-scale length never needs a wrapped count.
          if (cnt_q == len_q - 1'b1) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        accumulate = 1'b1;
        dcnt_d     = dcnt_q + 1'b1;
        if (dcnt_q == DRAIN_LAST) begin
          res_d   = resulta;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        accumulate = 1'b1;
        res_valid  = 1'b1;
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign res_data = res_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dsp_dot_sequencer.sv
// Directed bench: sequencer paired with dsp_slice, results checked through an expected-value queue.
module tb_dsp_dot_sequencer;

  localparam int unsigned SLICE_LAT = 4;
  localparam int unsigned LEN_W     = 8;

  logic             clk = 1'b0;
  logic             clr;
  logic             job_valid, job_ready, job_neg;
  logic [LEN_W-1:0] job_len;
  logic [63:0]      job_const;
  logic             op_valid, op_ready;
  logic [26:0]      op_a, op_b, ay, ax;
  logic             loadconst, accumulate, negate;
  logic [63:0]      constant, resulta, res_data;
  logic             res_valid, res_ready, busy;

  int ncmp = 0;
  int nerr = 0;
  logic [63:0] exp_q [$];
  logic prev_valid = 1'b0;
  int unsigned pa [256];
  int unsigned pb [256];

  always #5 clk = ~clk;

  dsp_dot_sequencer #(.SLICE_LAT(SLICE_LAT), .LEN_W(LEN_W)) dut (
    .clk(clk), .clr(clr),
    .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len),
    .job_const(job_const), .job_neg(job_neg),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .ay(ay), .ax(ax), .loadconst(loadconst), .accumulate(accumulate),
    .negate(negate), .constant(constant), .resulta(resulta),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .busy(busy)
  );

  dsp_slice #(.LAT(SLICE_LAT)) u_slice (
    .clk(clk), .rst(clr), .ay(ay), .ax(ax), .loadconst(loadconst),
    .accumulate(accumulate), .negate(negate), .constant(constant),
    .resulta(resulta)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one comparison per result presentation.
  always @(negedge clk) begin
    if (res_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        ncmp++;
        nerr++;
        $display("FAIL unexpected_result: got res_valid with data %0h, expected no result", res_data);
      end else begin
        check("res_data", res_data, exp_q.pop_front());
      end
    end
    prev_valid <= res_valid;
  end

  task automatic start_job(input int n, input logic [63:0] c, input logic neg);
    @(negedge clk);
    check("job_ready_idle", job_ready, 1'b1);
    @(posedge clk); #1;
    job_valid = 1'b1; job_len = LEN_W'(n); job_const = c; job_neg = neg;
    @(posedge clk); #1;
    job_valid = 1'b0; job_len = '0; job_const = '0; job_neg = 1'b0;
    @(negedge clk);
    check("load_loadconst", loadconst, 1'b1);
    check("load_constant", constant, c);
    check("load_job_ready", job_ready, 1'b0);
    check("load_busy", busy, 1'b1);
  endtask

  task automatic run_job(input int n, input logic [63:0] c, input logic neg, input logic [63:0] exp,
                         input int stall_at, input int stall_n, input int hold_n);
    int cyc;
    logic saw_opr;
    res_ready = (hold_n == 0);
    exp_q.push_back(exp);
    start_job(n, c, neg);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          @(posedge clk); #1;
          op_valid = 1'b0; op_a = 27'h5A5A; op_b = 27'h3C3C;
          @(negedge clk);
          check("stall_ay", ay, 0);
          check("stall_ax", ax, 0);
          check("stall_accumulate", accumulate, 1'b1);
          check("stall_op_ready", op_ready, 1'b1);
        end
      end
      @(posedge clk); #1;
      op_valid = 1'b1; op_a = 27'(pa[i]); op_b = 27'(pb[i]);
      @(negedge clk);
      if (i < 3) begin
        check("stream_op_ready", op_ready, 1'b1);
        check("stream_ay", ay, 64'(pa[i]));
        check("stream_ax", ax, 64'(pb[i]));
        check("stream_negate", negate, neg);
      end
    end
    if (n > 0) begin
      @(posedge clk); #1;
      op_valid = 1'b0;
    end
    cyc = 0;
    saw_opr = 1'b0;
    while (!res_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (op_ready) saw_opr = 1'b1;
    end
    check("latency", 64'(cyc), 64'(SLICE_LAT + 1));
    check("op_ready_after_stream", saw_opr, 1'b0);
    if (hold_n > 0) begin
      for (int h = 0; h < hold_n; h++) begin
        check("hold_res_valid", res_valid, 1'b1);
        check("hold_res_data", res_data, exp);
        check("hold_job_ready", job_ready, 1'b0);
        @(negedge clk);
      end
      @(posedge clk); #1;
      res_ready = 1'b1;
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("post_job_ready", job_ready, 1'b1);
    check("post_res_valid", res_valid, 1'b0);
    check("post_busy", busy, 1'b0);
  endtask

  initial begin
    clr = 1'b1; job_valid = 1'b0; job_len = '0; job_const = '0; job_neg = 1'b0;
    op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b1;
    #2;
    check("rst_job_ready", job_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_op_ready", op_ready, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_loadconst", loadconst, 1'b0);
    check("rst_accumulate", accumulate, 1'b0);
    check("rst_constant", constant, 0);
    check("rst_res_data", res_data, 0);
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;

    pa[0] = 2; pb[0] = 3; pa[1] = 4; pb[1] = 5; pa[2] = 6; pb[2] = 7;
    run_job(3, 64'd0, 1'b0, 64'd68, -1, 0, 0);

    pa[0] = 3; pb[0] = 3; pa[1] = 1; pb[1] = 10;
    run_job(2, 64'd100, 1'b1, 64'd81, -1, 0, 0);

    pa[0] = 2; pb[0] = 3; pa[1] = 4; pb[1] = 5; pa[2] = 6; pb[2] = 7;
    run_job(3, 64'd0, 1'b0, 64'd68, 1, 4, 0);

    run_job(0, 64'h1234, 1'b0, 64'h1234, -1, 0, 0);

    pa[0] = 7; pb[0] = 8;
    run_job(1, 64'd5, 1'b0, 64'd61, -1, 0, 10);

    // Abort mid-stream: no result may appear.
    pa[0] = 9; pb[0] = 9; pa[1] = 8; pb[1] = 8;
    start_job(3, 64'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      op_valid = 1'b1; op_a = 27'(pa[i]); op_b = 27'(pb[i]);
    end
    @(negedge clk);
    check("abort_in_stream", op_ready, 1'b1);
    #2 clr = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_job_ready", job_ready, 1'b1);
    check("abort_op_ready", op_ready, 1'b0);
    check("abort_accumulate", accumulate, 1'b0);
    op_valid = 1'b0;
    @(posedge clk); #1 clr = 1'b0;
    for (int k = 0; k < int'(SLICE_LAT) + 4; k++) begin
      @(negedge clk);
      check("abort_no_result", res_valid, 1'b0);
    end

    pa[0] = 5; pb[0] = 5;
    run_job(1, 64'd0, 1'b0, 64'd25, -1, 0, 0);

    for (int i = 0; i < 255; i++) begin pa[i] = 1; pb[i] = 1; end
    run_job(255, 64'd0, 1'b0, 64'd255, -1, 0, 0);

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/dsp_dot_sequencer.md
DSP_DOT_SEQUENCER -- requirements
Module: dsp_dot_sequencer

Interface
REQ-001 Parameter SLICE_LAT, default 4: cycles from a beat on the slice ports to its effect on slice resulta.
REQ-002 Parameter LEN_W, default 8: width of the job length field.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 clr  input  1  reset; asynchronous, active-high.
REQ-005 job_valid  input  1  job request present.
REQ-006 job_ready  output  1  sequencer can accept a job (high only in IDLE).
REQ-007 job_len  input  LEN_W  number of operand pairs N in the job.
REQ-008 job_const  input  64  accumulator initial value.
REQ-009 job_neg  input  1  subtract products instead of adding them, for the whole job.
REQ-010 op_valid  input  1  operand pair present.
REQ-011 op_ready  output  1  operand pair accepted this cycle.
REQ-012 op_a  input  27  first operand; op_b  input  27  second operand.
REQ-013 ay, ax  output  27 each  to slice operand ports.
REQ-014 loadconst, accumulate, negate  output  1 each  to slice control ports.
REQ-015 constant  output  64  to slice constant port.
REQ-016 resulta  input  64  from slice result port.
REQ-017 res_valid  output  1  result available; res_data  output  64  dot-product result; res_ready  input  1  consumer accepts.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, STREAM, DRAIN, DONE.
REQ-020 IDLE: job_ready=1; on job_valid, job_len, job_const and job_neg SHALL be registered and the next state SHALL be LOAD.
REQ-021 LOAD (exactly 1 cycle): loadconst=1, accumulate=0, negate=0, ay=ax=0, constant=registered job_const; next state STREAM if N>0, else DRAIN.
REQ-022 STREAM: op_ready=1; each cycle accumulate=1, loadconst=0, negate=registered job_neg.
REQ-023 STREAM, op_valid=1: ay=op_a, ax=op_b; the beat counter SHALL increment.
REQ-024 STREAM, op_valid=0 (stall): ay=ax=0, i.e. a hold beat; the counter SHALL NOT increment.
REQ-025 When the N-th pair is accepted, the next state SHALL be DRAIN with op_ready=0 from the following cycle.
REQ-026 DRAIN: hold beats (accumulate=1, ay=ax=0) for exactly SLICE_LAT cycles.
REQ-027 At the end of DRAIN, res_data SHALL capture resulta and the next state SHALL be DONE.
REQ-028 DONE: res_valid=1 and res_data stable; hold beats continue; on res_ready=1, go to IDLE.
REQ-029 In IDLE and DONE, op_ready=0 and no operand SHALL be consumed.
REQ-030 Outside LOAD, constant SHALL be 0.
REQ-031 Outside IDLE, job_valid SHALL be ignored.
REQ-032 A job and a result handshake SHALL NOT complete in the same cycle, giving a minimum of 1 idle cycle between jobs.
REQ-033 job_len=0 SHALL produce res_data=job_const.
REQ-034 The beat counter SHALL be LEN_W bits; N=2^LEN_W-1 SHALL complete without wrap.
REQ-035 Latency, last accepted pair to res_valid: SLICE_LAT+1 cycles.

Reset
REQ-036 While clr=1, the sequencer SHALL be in IDLE with all outputs 0 except job_ready=1.
REQ-037 clr asserted mid-job SHALL abort the job with no result emitted; the next job SHALL start from LOAD.

Structure
REQ-038 The shared package SHALL hold the state enum, the 64-bit accumulator width and the 27-bit operand width constants.
REQ-039 Single module with no sub-modules; the bench instantiates dsp_slice as the DUT's partner.

Verification
REQ-040 Scenario: N=3, const=0, pairs (2,3)(4,5)(6,7) -> res_data=68, res_valid at cycle SLICE_LAT+1 after the last pair.
REQ-041 Scenario: N=2, const=100, neg=1, pairs (3,3)(1,10) -> res_data=81.
REQ-042 Scenario: N=3 with op_valid low for 4 cycles between pairs 1 and 2 -> same result as with no stall; hold beats visible on the slice ports.
REQ-043 Scenario: N=0, const=64'h1234 -> res_data=64'h1234; op_ready never asserted.
REQ-044 Scenario: res_ready held low 10 cycles -> res_data stable and res_valid high throughout; job_ready=0 until release.
REQ-045 Scenario: clr pulsed during STREAM -> IDLE immediately, no res_valid; the following job N=1, (5,5), const=0 -> 25.
